control_word_register: RTL
==========================

CONTROL_WORD_REGISTER -- requirements
Module: control_word_register

Interface
REQ-001 Parameter WORD_W, default 34, width of the microstore control word.
REQ-002 Parameter STATE_W, default 10, width of the microstore state address.
REQ-003 Parameter NOP_WORD, default all-zeros (WORD_W bits), word loaded on reset and on flush.
REQ-004 Parameter N_LSB, default 31, LSB of the 3-bit N (next-address mode) field in the word.
REQ-005 Parameter INV_BIT, default 30, bit position of the inv field.
REQ-006 Parameter SEL_LSB, default 28, LSB of the 2-bit select field.
REQ-007 Parameter CR_LSB, default 0, LSB of the 6-bit cr (constant/literal) field.
REQ-008 Parameter STALL_MAX, default 15, stall-cycle limit before timeout; range 1..255.
REQ-009 clk  input  1  rising-edge clock; the only clock.
REQ-010 reset_n  input  1  synchronous active-low reset.
REQ-011 in  input  WORD_W  control word from the microstore.
REQ-012 in_state  input  STATE_W  microstore address that produced in.
REQ-013 stall  input  1  hold the current word.
REQ-014 flush  input  1  replace the current word with NOP_WORD.
REQ-015 save  input  1  copy the current word and state into the shadow register.
REQ-016 restore  input  1  reload the word and state from the shadow register.
REQ-017 word_q  output  WORD_W  registered control word; all non-decoded fields are taken from it.
REQ-018 state_q  output  STATE_W  address of the word in word_q.
REQ-019 N  output  3  word_q[N_LSB+2:N_LSB].
REQ-020 inv  output  1  word_q[INV_BIT].
REQ-021 select  output  2  word_q[SEL_LSB+1:SEL_LSB].
REQ-022 cr  output  6  word_q[CR_LSB+5:CR_LSB].
REQ-023 shadow_valid  output  1  the shadow register holds saved contents.
REQ-024 restore_err  output  1  one-cycle pulse when a restore request finds the shadow register empty.
REQ-025 stall_timeout  output  1  sticky flag: the stall limit has been exceeded.

Function
REQ-026 All registers SHALL update only on the rising edge of clk; N, inv, select and cr SHALL be pure combinational slices of word_q.
REQ-027 Update priority per edge: reset_n low > flush > restore > stall > normal load.
REQ-028 Normal load (no control asserted): word_q<=in and state_q<=in_state, giving 1-cycle latency from in to word_q.
REQ-029 Flush: word_q<=NOP_WORD, state_q<=0, stall counter <=0, stall_timeout<=0; shadow contents and shadow_valid are unchanged.
REQ-030 Restore with shadow_valid=1: word_q and state_q <= shadow contents, shadow_valid<=0.
REQ-031 Restore with shadow_valid=0: word_q and state_q hold, and restore_err=1 for exactly one cycle.
REQ-032 Stall: word_q and state_q hold; the stall counter increments, saturating at 255.
REQ-033 Stall timeout: when the stall counter reaches STALL_MAX while stall is still asserted, stall_timeout<=1 on that edge.
REQ-034 stall_timeout SHALL stay at 1 until a flush or a reset clears it.
REQ-035 When stall is low, the stall counter <=0 on that edge; stall_timeout is not cleared by this.
REQ-036 Save shadows the pre-edge word_q/state_q and sets shadow_valid<=1.
REQ-037 Save is independent of the word_q update priority and may combine with load, stall or flush; it overwrites an existing shadow.
REQ-038 Save and restore in the same cycle: restore uses the old shadow; the shadow then takes the pre-edge word_q/state_q and shadow_valid=1.
REQ-039 Inputs sampled while flush is high SHALL NOT appear at word_q.

Reset
REQ-040 reset_n low at an edge: word_q=NOP_WORD, state_q=0, shadow register=0, shadow_valid=0, restore_err=0, stall counter=0, stall_timeout=0.
REQ-041 Reset SHALL override every concurrent request, including save, restore and flush.
REQ-042 Reset mid-stall or with the shadow register full SHALL discard all pending state.

Verification
REQ-043 Load: in=34'h2_AAAA_AAAA, in_state=4, no controls -> next edge word_q=34'h2_AAAA_AAAA, state_q=4, N=3'b101, inv=0, select=2'b10.
REQ-044 Stall timeout: load state 20, then stall for 15 cycles -> word_q/state_q hold; stall_timeout rises on the 15th edge; it stays high after stall drops; flush clears it and gives word_q=0.
REQ-045 Save/restore: save while state_q=4, load states 5 and 6, then restore -> state_q=4 with its original word; shadow_valid 1 then 0.
REQ-046 Restore when empty: restore with shadow_valid=0 -> restore_err high for one cycle only; word_q unchanged.
REQ-047 Priority: flush+restore+stall together -> word_q=NOP_WORD, state_q=0, shadow_valid unchanged.
REQ-048 Reset mid-operation: reset_n low during stall with the shadow full -> all outputs match REQ-040 on the next edge.
REQ-049 Recovery: after reset_n returns high, normal load resumes on the next edge.

Source files
------------

// File: rtl/control_word_register.sv
// Control word pipeline register for the microstore: holds the current word and
// its address, with flush, stall (with timeout), and a one-deep shadow for save/restore.
module control_word_register #(
    parameter int unsigned       WORD_W    = 34,
    parameter int unsigned       STATE_W   = 10,
    parameter logic [WORD_W-1:0] NOP_WORD  = '0,
    parameter int unsigned       N_LSB     = 31,
    parameter int unsigned       INV_BIT   = 30,
    parameter int unsigned       SEL_LSB   = 28,
    parameter int unsigned       CR_LSB    = 0,
    parameter int unsigned       STALL_MAX = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WORD_W-1:0]  in,
    input  logic [STATE_W-1:0] in_state,
    input  logic               stall,
    input  logic               flush,
    input  logic               save,
    input  logic               restore,
    output logic [WORD_W-1:0]  word_q,
    output logic [STATE_W-1:0] state_q,
    output logic [2:0]         N,
    output logic               inv,
    output logic [1:0]         select,
    output logic [5:0]         cr,
    output logic               shadow_valid,
    output logic               restore_err,
    output logic               stall_timeout
);

    localparam logic [7:0] STALL_MAX_C = 8'(STALL_MAX);

    logic [WORD_W-1:0]  word_d;
    logic [STATE_W-1:0] state_d;
    logic [WORD_W-1:0]  shadow_word_q, shadow_word_d;
    logic [STATE_W-1:0] shadow_state_q, shadow_state_d;
    logic               shadow_valid_q, shadow_valid_d;
    logic               restore_err_q, restore_err_d;
    logic [7:0]         stall_cnt_q, stall_cnt_d;
    logic               stall_timeout_q, stall_timeout_d;

    always_comb begin
        word_d          = word_q;
        state_d         = state_q;
        shadow_word_d   = shadow_word_q;
        shadow_state_d  = shadow_state_q;
        shadow_valid_d  = shadow_valid_q;
        restore_err_d   = 1'b0;
        stall_cnt_d     = stall_cnt_q;
        stall_timeout_d = stall_timeout_q;

        if (flush) begin
            word_d          = NOP_WORD;
            state_d         = '0;
            stall_cnt_d     = '0;
            stall_timeout_d = 1'b0;
        end else begin
            if (restore) begin
                if (shadow_valid_q) begin
                    word_d         = shadow_word_q;
                    state_d        = shadow_state_q;
                    shadow_valid_d = 1'b0;
                end else begin
                    restore_err_d = 1'b1;
                end
            end else if (!stall) begin
                word_d  = in;
                state_d = in_state;
            end

            // Stall counting follows the stall input even when a restore wins the word update.
            if (stall) begin
                stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
                if (stall_cnt_d >= STALL_MAX_C) begin
                    stall_timeout_d = 1'b1;
                end
            end else begin
                stall_cnt_d = '0;
            end
        end

        // Save always captures the pre-edge contents, after any restore has read the old shadow.
        if (save) begin
            shadow_word_d  = word_q;
            shadow_state_d = state_q;
            shadow_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_q          <= NOP_WORD;
            state_q         <= '0;
            shadow_word_q   <= '0;
            shadow_state_q  <= '0;
            shadow_valid_q  <= 1'b0;
            restore_err_q   <= 1'b0;
            stall_cnt_q     <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            word_q          <= word_d;
            state_q         <= state_d;
            shadow_word_q   <= shadow_word_d;
            shadow_state_q  <= shadow_state_d;
            shadow_valid_q  <= shadow_valid_d;
            restore_err_q   <= restore_err_d;
            stall_cnt_q     <= stall_cnt_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign N             = word_q[N_LSB+2:N_LSB];
    assign inv           = word_q[INV_BIT];
    assign select        = word_q[SEL_LSB+1:SEL_LSB];
    assign cr            = word_q[CR_LSB+5:CR_LSB];
    assign shadow_valid  = shadow_valid_q;
    assign restore_err   = restore_err_q;
    assign stall_timeout = stall_timeout_q;

endmodule
